// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier.
// State encoding is fixed so downstream debug tools can decode it.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier with valid/ready handshakes.
// Terminates as soon as the remaining multiplier bits are all zero.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH:0]   product,
    output logic                    busy
);

    localparam int PW = 2*DATA_WIDTH + 1;

    mult_state_t           state, state_n;
    logic [PW-1:0]         mcand, mcand_n;
    logic [PW-1:0]         acc, acc_n;
    logic [DATA_WIDTH-1:0] mplier, mplier_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else begin
            state  <= state_n;
            mcand  <= mcand_n;
            acc    <= acc_n;
            mplier <= mplier_n;
        end
    end

    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        acc_n    = acc;
        mplier_n = mplier;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_n  = {{(PW-DATA_WIDTH){1'b0}}, op_a};
                    mplier_n = op_b;
                    acc_n    = '0;
                    state_n  = (op_a == '0 || op_b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (mplier[0])
                    acc_n = acc + mcand;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                if (mplier_n == '0)
                    state_n = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            // 2'b11 is unreachable; recover to IDLE
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign product   = acc;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-add multiplier that forms the full-width product of two DATA_WIDTH-bit unsigned operands and hands it, through a valid/ready handshake, to the modulo reduction stage directly downstream. Its output width (2*DATA_WIDTH+1) matches that stage's dividend input, with the MSB always zero. Latency scales with the position of the most significant set bit of the multiplier, so small operands finish early.

## Interface
- DATA_WIDTH, default 8: operand width in bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present on op_a/op_b
- in_ready  out  1  block can accept operands (high only in IDLE)
- op_a  in  DATA_WIDTH  multiplicand, unsigned
- op_b  in  DATA_WIDTH  multiplier, unsigned
- out_valid  out  1  product valid (high only in DONE)
- out_ready  in  1  downstream accepts product
- product  out  2*DATA_WIDTH+1  op_a*op_b, zero-extended; MSB always 0
- busy  out  1  state is RUN

## Operation
- Registers:
  - mcand, 2*DATA_WIDTH+1 bits, zero-extended op_a.
  - mplier, DATA_WIDTH bits.
  - acc, 2*DATA_WIDTH+1 bits.
  - state.
- IDLE:
  - in_ready=1.
  - On in_valid: latch mcand=op_a, mplier=op_b, acc=0.
  - If op_a==0 or op_b==0, go to DONE (acc stays 0); else go to RUN.
- RUN, every cycle:
  - acc += mplier[0] ? mcand : 0
  - mcand <<= 1
  - mplier >>= 1
  - Exit to DONE when the shifted mplier is 0 (early termination). This takes at most DATA_WIDTH cycles.
- DONE:
  - out_valid=1; product=acc, held stable.
  - On out_ready: go to IDLE.
  - in_ready=0, so in_valid is ignored.
- Arithmetic:
  - All additions are unsigned at 2*DATA_WIDTH+1 bits and cannot overflow.
  - mcand shifts never lose set bits before termination.
- Outputs:
  - product is driven from acc.
  - product is only meaningful while out_valid=1.
  - Operand inputs are don't-care outside the accept cycle.

## Timing
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0. Hence out_valid=0, product=0, busy=0, in_ready=1.
- Reset asserted at any time, including mid-RUN or in DONE:
  - Immediately returns to reset values.
  - An in-flight product is discarded; no out_valid pulse is produced.
- Accept edge E0 is the rising edge with state==IDLE and in_valid=1. Let k = index of the highest set bit of op_b, plus 1.
  - Either operand zero: out_valid=1 during the cycle after E0.
  - Otherwise: RUN for k cycles; out_valid first high after edge E0+k.
  - DATA_WIDTH=8 worst case is 8 RUN cycles.
- Handshake:
  - Product transfer completes on the edge where out_valid and out_ready are both 1.
  - in_ready rises the following cycle.
  - Minimum back-to-back throughput: one operation per k+2 cycles.
- out_ready asserted while not in DONE has no effect.
- in_valid held high continuously: a new operand pair is accepted on the first IDLE edge after each transfer.

## Structure
- Shared package mult_pkg holds the state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- Unused encoding 2'b11 maps to IDLE in the next-state logic.
- Single module with one sequential process and one combinational next-state/datapath process.
- No sub-module: the datapath is one adder plus two shifters.

## Test plan
All scenarios use DATA_WIDTH=8.
- op_a=13, op_b=11: product=143. out_valid 4 cycles after accept; busy high exactly 4 cycles.
- op_a=255, op_b=255: product=65025 (17'h0FE01), MSB 0. out_valid 8 cycles after accept.
- op_a=0, op_b=200, then op_a=77, op_b=0: both give product=0 with out_valid 1 cycle after accept, busy never high.
- op_a=1, op_b=128: product=128 after 8 RUN cycles. op_a=200, op_b=1: product=200 after 1 RUN cycle.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required: product stable, in_ready=0, new operands not latched.
  - After out_ready=1, the next accepted pair is the one present in IDLE.
- Reset mid-operation:
  - Drop rst_n during RUN of 255*255.
  - Required: outputs at reset values immediately, no out_valid.
  - After release, 6*7 yields 42.
